// File: rtl/oven_pkg.sv
// oven_pkg: shared types and field widths for the oven cook timer.
//   state_t   : controller states (IDLE, ARMED, RUN, PAUSE, ALARM)
//   MIN_W     : width of the minute field
//   SEC_W     : width of the second field
//   SEC_MAX   : largest legal seconds value
package oven_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RUN,
        PAUSE,
        ALARM
    } state_t;

    localparam int MIN_W = 7;
    localparam int SEC_W = 6;

    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/tick_sync.sv
// tick_sync: brings an asynchronous toggle signal into the clk domain and
// turns every edge of it (rising or falling) into a one-cycle strobe.
// A toggle edge shows up as stb high during the third clk edge after it.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous, active-high reset
//   tgl  in  asynchronous toggle input
//   stb  out one-cycle strobe per toggle edge
module tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic tgl,
    output logic stb
);

    logic tgl_p0;
    logic tgl_p1;
    logic tgl_p2;

    // p0/p1: two-flop synchronizer; p2: previous synced value for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            tgl_p0 <= 1'b0;
            tgl_p1 <= 1'b0;
            tgl_p2 <= 1'b0;
        end else begin
            tgl_p0 <= tgl;
            tgl_p1 <= tgl_p0;
            tgl_p2 <= tgl_p1;
        end
    end

    assign stb = tgl_p1 ^ tgl_p2;

endmodule

// File: rtl/oven_countdown.sv
// oven_countdown: oven cook timer counting down MM:SS from a loaded setpoint,
// clocked by 1 ms toggle edges from the prescaler.
// Optional build macro: OVEN_DOOR_INTERLOCK_EN adds a door_open input that
// pauses a running cook, blocks start and gates the heater.
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   tick_tgl             1 ms toggle from prescaler (each edge = 1 ms)
//   set_min, set_sec     setpoint (clamped to MAX_MIN / 59 on load)
//   load/start/pause/cancel  one-cycle command pulses, cancel highest priority
//   door_open            (interlock build only) door switch, asynchronous
//   remain_min/sec       remaining time
//   running, heater_en   high in RUN (heater also gated by door in interlock build)
//   done                 one-cycle pulse on reaching 0:00
//   buzzer               high in ALARM
module oven_countdown
    import oven_pkg::*;
#(
    parameter int MS_PER_S = 1000,
    parameter int BUZZ_MS  = 3000,
    parameter int MAX_MIN  = 99
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_tgl,
    input  logic [MIN_W-1:0] set_min,
    input  logic [SEC_W-1:0] set_sec,
    input  logic             load,
    input  logic             start,
    input  logic             pause,
    input  logic             cancel,
`ifdef OVEN_DOOR_INTERLOCK_EN
    input  logic             door_open,
`endif
    output logic [MIN_W-1:0] remain_min,
    output logic [SEC_W-1:0] remain_sec,
    output logic             running,
    output logic             heater_en,
    output logic             done,
    output logic             buzzer
);

    localparam int MS_W   = $clog2(MS_PER_S);
    localparam int BUZZ_W = $clog2(BUZZ_MS + 1);

    localparam logic [MS_W-1:0]   MS_LAST   = MS_W'(MS_PER_S - 1);
    localparam logic [BUZZ_W-1:0] BUZZ_LAST = BUZZ_W'(BUZZ_MS - 1);

    function automatic logic [MIN_W-1:0] clamp_min(input logic [MIN_W-1:0] m);
        return (m > MIN_W'(MAX_MIN)) ? MIN_W'(MAX_MIN) : m;
    endfunction

    function automatic logic [SEC_W-1:0] clamp_sec(input logic [SEC_W-1:0] s);
        return (s > SEC_MAX) ? SEC_MAX : s;
    endfunction

    state_t             state, state_n;
    logic [MIN_W-1:0]   min_n;
    logic [SEC_W-1:0]   sec_n;
    logic [MS_W-1:0]    ms_cnt, ms_n;
    logic [BUZZ_W-1:0]  buzz_cnt, buzz_n;
    logic               done_n;
    logic               ms_stb;
    logic               start_ok;
    logic               door_hold;

    tick_sync u_tick_sync (
        .clk (clk),
        .rst (rst),
        .tgl (tick_tgl),
        .stb (ms_stb)
    );

`ifdef OVEN_DOOR_INTERLOCK_EN
    logic door_p0;
    logic door_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            door_p0 <= 1'b0;
            door_p1 <= 1'b0;
        end else begin
            door_p0 <= door_open;
            door_p1 <= door_p0;
        end
    end

    assign door_hold = door_p1;
    assign start_ok  = start & ~door_p1;
`else
    assign door_hold = 1'b0;
    assign start_ok  = start;
`endif

    always_comb begin
        state_n = state;
        min_n   = remain_min;
        sec_n   = remain_sec;
        ms_n    = ms_cnt;
        buzz_n  = buzz_cnt;
        done_n  = 1'b0;

        if (cancel) begin
            state_n = IDLE;
            min_n   = '0;
            sec_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!pause && !start && load) begin
                        min_n   = clamp_min(set_min);
                        sec_n   = clamp_sec(set_sec);
                        state_n = ARMED;
                    end
                end
                ARMED: begin
                    if (pause) begin
                        state_n = ARMED;
                    end else if (start) begin
                        if (start_ok && (remain_min != '0 || remain_sec != '0)) begin
                            ms_n    = '0;
                            state_n = RUN;
                        end
                    end else if (load) begin
                        min_n = clamp_min(set_min);
                        sec_n = clamp_sec(set_sec);
                    end
                end
                RUN: begin
                    // a strobe coinciding with pause (or an open door) is dropped
                    if (pause || door_hold) begin
                        state_n = PAUSE;
                    end else if (ms_stb) begin
                        if (ms_cnt == MS_LAST) begin
                            ms_n = '0;
                            if (remain_sec != '0) begin
                                sec_n = remain_sec - SEC_W'(1);
                            end else begin
                                sec_n = SEC_MAX;
                                min_n = remain_min - MIN_W'(1);
                            end
                            if (remain_min == '0 && remain_sec == SEC_W'(1)) begin
                                done_n  = 1'b1;
                                buzz_n  = '0;
                                state_n = ALARM;
                            end
                        end else begin
                            ms_n = ms_cnt + MS_W'(1);
                        end
                    end
                end
                PAUSE: begin
                    if (!pause && start_ok) begin
                        state_n = RUN;
                    end
                end
                ALARM: begin
                    if (ms_stb) begin
                        if (buzz_cnt == BUZZ_LAST) begin
                            state_n = IDLE;
                        end else begin
                            buzz_n = buzz_cnt + BUZZ_W'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // register stage: state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remain_min <= '0;
            remain_sec <= '0;
            ms_cnt     <= '0;
            buzz_cnt   <= '0;
            running    <= 1'b0;
            heater_en  <= 1'b0;
            done       <= 1'b0;
            buzzer     <= 1'b0;
        end else begin
            state      <= state_n;
            remain_min <= min_n;
            remain_sec <= sec_n;
            ms_cnt     <= ms_n;
            buzz_cnt   <= buzz_n;
            running    <= (state_n == RUN);
            heater_en  <= (state_n == RUN) & ~door_hold;
            done       <= done_n;
            buzzer     <= (state_n == ALARM);
        end
    end

endmodule

// File: tb/tb_oven_countdown.sv
// tb_oven_countdown: directed self-checking bench for oven_countdown with the
// default parameters (1000 ms per second, 3000 ms buzzer).
module tb_oven_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_tgl;
    logic [6:0] set_min;
    logic [5:0] set_sec;
    logic       load, start, pause, cancel;
`ifdef OVEN_DOOR_INTERLOCK_EN
    logic       door_open;
`endif
    logic [6:0] remain_min;
    logic [5:0] remain_sec;
    logic       running, heater_en, done, buzzer;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int done_ref;

    oven_countdown dut (
        .clk        (clk),
        .rst        (rst),
        .tick_tgl   (tick_tgl),
        .set_min    (set_min),
        .set_sec    (set_sec),
        .load       (load),
        .start      (start),
        .pause      (pause),
        .cancel     (cancel),
`ifdef OVEN_DOOR_INTERLOCK_EN
        .door_open  (door_open),
`endif
        .remain_min (remain_min),
        .remain_sec (remain_sec),
        .running    (running),
        .heater_en  (heater_en),
        .done       (done),
        .buzzer     (buzzer)
    );

    always #5 clk = ~clk;

    // done is registered on posedge, so each pulse spans exactly one negedge
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ctl(input logic c, input logic p, input logic s, input logic l);
        @(negedge clk);
        cancel = c; pause = p; start = s; load = l;
        @(negedge clk);
        cancel = 1'b0; pause = 1'b0; start = 1'b0; load = 1'b0;
    endtask

    task automatic do_load(input logic [6:0] m, input logic [5:0] s);
        set_min = m;
        set_sec = s;
        ctl(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // one toggle every 4 clk; returns once the last strobe has been consumed
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick_tgl = ~tick_tgl;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic chk_time(input string tag, input int m, input int s);
        check({tag, "_min"}, remain_min, m);
        check({tag, "_sec"}, remain_sec, s);
    endtask

    initial begin
        rst = 1'b1; tick_tgl = 1'b0; set_min = '0; set_sec = '0;
        load = 1'b0; start = 1'b0; pause = 1'b0; cancel = 1'b0;
`ifdef OVEN_DOOR_INTERLOCK_EN
        door_open = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset state
        chk_time("rst", 0, 0);
        check("rst_running", running, 0);
        check("rst_heater", heater_en, 0);
        check("rst_done", done, 0);
        check("rst_buzzer", buzzer, 0);

        // IDLE ignores start
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_start_ign", running, 0);

        // full cook 0:02 then alarm
        do_load(7'd0, 6'd2);
        chk_time("load02", 0, 2);
        check("armed_running", running, 0);
        done_ref = done_cnt;
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("run_running", running, 1);
        check("run_heater", heater_en, 1);
        tick(999);
        chk_time("s999", 0, 2);
        tick(1);
        chk_time("s1000", 0, 1);
        tick(999);
        chk_time("s1999", 0, 1);
        check("s1999_done", done, 0);
        tick(1);
        chk_time("s2000", 0, 0);
        check("s2000_done", done, 1);
        check("s2000_buzzer", buzzer, 1);
        check("s2000_running", running, 0);
        check("s2000_heater", heater_en, 0);
        @(negedge clk);
        check("done_width", done, 0);
        tick(2999);
        check("buzz_2999", buzzer, 1);
        tick(1);
        check("buzz_3000", buzzer, 0);
        check("done_count", done_cnt - done_ref, 1);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("alarm_to_idle", running, 0);

        // minute borrow
        do_load(7'd1, 6'd0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1000);
        chk_time("borrow", 0, 59);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("cancel_run", 0, 0);
        check("cancel_running", running, 0);

        // setpoint clamps
        do_load(7'd120, 6'd63);
        chk_time("clamp", 99, 59);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);
        chk_time("cancel_armed", 0, 0);

        // pause retains ms_cnt, strobes in PAUSE ignored
        do_load(7'd0, 6'd5);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        tick(400);
        ctl(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause_running", running, 0);
        check("pause_heater", heater_en, 0);
        tick(500);
        chk_time("pause_hold", 0, 5);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("resume_running", running, 1);
        tick(599);
        chk_time("resume_599", 0, 5);
        tick(1);
        chk_time("resume_600", 0, 4);
        ctl(1'b1, 1'b0, 1'b0, 1'b0);

        // start with 0:00 in ARMED is ignored, state stays ARMED
        do_load(7'd0, 6'd0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("armed_zero_start", running, 0);
        do_load(7'd0, 6'd3);
        chk_time("armed_reload", 0, 3);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("armed_start", running, 1);

        // cancel wins over start in the same cycle
        ctl(1'b1, 1'b0, 1'b1, 1'b0);
        check("cancel_start_run", running, 0);
        chk_time("cancel_start", 0, 0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("cancel_start_idle", running, 0);

        // reset in the middle of RUN at 1:30
        do_load(7'd1, 6'd30);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        tick(10);
        check("pre_rst_heater", heater_en, 1);
        done_ref = done_cnt;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_time("midrst", 0, 0);
        check("midrst_heater", heater_en, 0);
        check("midrst_running", running, 0);
        repeat (4) @(negedge clk);
        check("midrst_nodone", done_cnt - done_ref, 0);

`ifdef OVEN_DOOR_INTERLOCK_EN
        // door opened during RUN forces PAUSE; start blocked until closed
        do_load(7'd0, 6'd5);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("door_run", running, 1);
        @(negedge clk);
        door_open = 1'b1;
        repeat (4) @(negedge clk);
        check("door_pause", running, 0);
        check("door_heater", heater_en, 0);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("door_start_ign", running, 0);
        door_open = 1'b0;
        repeat (4) @(negedge clk);
        ctl(1'b0, 1'b0, 1'b1, 1'b0);
        check("door_resume", running, 1);
        check("door_heater_on", heater_en, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
